// File: rtl/shiftreg_transfer_controller_if.sv
// Control/strobe bundle between the transfer controller and its surroundings.
// The controller takes the master modport; the driver side takes the slave modport.
interface shiftreg_transfer_controller_if;
  logic       start;
  logic       abort;
  logic       sr_load;
  logic       sr_shift;
  logic       sclk;
  logic       cs_n;
  logic       busy;
  logic       done;
  logic [5:0] bit_count;

  modport master (
    input  start, abort,
    output sr_load, sr_shift, sclk, cs_n, busy, done, bit_count
  );

  modport slave (
    output start, abort,
    input  sr_load, sr_shift, sclk, cs_n, busy, done, bit_count
  );
endinterface

// File: rtl/shiftreg_transfer_controller.sv
// SPI-mode-0 style sequencer for a parallel-load / serial-shift register:
// one load strobe, CS setup, WIDTH divided sclk periods with a shift strobe each, CS hold, done.
module shiftreg_transfer_controller #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  shiftreg_transfer_controller_if.master      xfer_io
);

  localparam int unsigned CntMax = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] DivLast   = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] SetupLast = CntW'(CS_SETUP - 1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  localparam logic [5:0]      WidthVal  = 6'(WIDTH);

  typedef enum logic [2:0] {StIdle, StSetup, StLow, StHigh, StHold} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [5:0]      bit_count_q;
  logic            sr_load_q;
  logic            sr_shift_q;
  logic            sclk_q;
  logic            cs_n_q;
  logic            busy_q;
  logic            done_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_count_q <= '0;
      sr_load_q   <= 1'b0;
      sr_shift_q  <= 1'b0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      sr_load_q  <= 1'b0;
      sr_shift_q <= 1'b0;
      done_q     <= 1'b0;
      if (xfer_io.abort && (state_q != StIdle)) begin
        // Shift strobe defaulted low above, so a pending strobe is dropped here.
        state_q <= StIdle;
        sclk_q  <= 1'b0;
        cs_n_q  <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (xfer_io.start) begin
              state_q     <= StSetup;
              cnt_q       <= SetupLast;
              bit_count_q <= '0;
              sr_load_q   <= 1'b1;
              cs_n_q      <= 1'b0;
              busy_q      <= 1'b1;
            end
          end
          StSetup: begin
            if (cnt_q == '0) begin
              state_q <= StLow;
              cnt_q   <= DivLast;
            end else begin
              cnt_q <= cnt_q - CntOne;
            end
          end
          StLow: begin
            if (cnt_q == '0) begin
              state_q <= StHigh;
              sclk_q  <= 1'b1;
              cnt_q   <= DivLast;
              // With a one-cycle high phase the first high cycle is also the last.
              if (CLK_DIV == 1) begin
                sr_shift_q  <= 1'b1;
                bit_count_q <= bit_count_q + 6'd1;
              end
            end else begin
              cnt_q <= cnt_q - CntOne;
            end
          end
          StHigh: begin
            if (cnt_q == '0) begin
              sclk_q <= 1'b0;
              if (bit_count_q >= WidthVal) begin
                state_q <= StHold;
                cnt_q   <= SetupLast;
              end else begin
                state_q <= StLow;
                cnt_q   <= DivLast;
              end
            end else begin
              cnt_q <= cnt_q - CntOne;
              if (cnt_q == CntOne) begin
                sr_shift_q  <= 1'b1;
                bit_count_q <= bit_count_q + 6'd1;
              end
            end
          end
          StHold: begin
            if (cnt_q == '0) begin
              state_q <= StIdle;
              cs_n_q  <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CntOne;
            end
          end
          default: begin
            state_q <= StIdle;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign xfer_io.sr_load   = sr_load_q;
  assign xfer_io.sr_shift  = sr_shift_q;
  assign xfer_io.sclk      = sclk_q;
  assign xfer_io.cs_n      = cs_n_q;
  assign xfer_io.busy      = busy_q;
  assign xfer_io.done      = done_q;
  assign xfer_io.bit_count = bit_count_q;

endmodule

// File: tb/tb_shiftreg_transfer_controller.sv
// Scoreboard bench: expected load/sclk-rise/shift/done events are queued when a start is
// driven and matched, in order, against events seen on the falling clock edge.
module tb_shiftreg_transfer_controller;

  localparam int KRise  = 0;
  localparam int KShift = 1;
  localparam int KLoad  = 2;
  localparam int KDone  = 3;

  typedef struct {
    int inst;
    int kind;
    int cyc;
    int bc;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  ev_t  exp_q[$];
  int   cs_low[2];
  int   exp_cs_low[2];
  logic prev_sclk[2];

  shiftreg_transfer_controller_if ifa ();
  shiftreg_transfer_controller_if ifb ();

  shiftreg_transfer_controller #(
    .WIDTH    (8),
    .CLK_DIV  (4),
    .CS_SETUP (2)
  ) u_dut_a (
    .clk_i   (clk),
    .rst_i   (rst),
    .xfer_io (ifa)
  );

  shiftreg_transfer_controller #(
    .WIDTH    (32),
    .CLK_DIV  (1),
    .CS_SETUP (1)
  ) u_dut_b (
    .clk_i   (clk),
    .rst_i   (rst),
    .xfer_io (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic match(input int inst, input int kind, input int bc);
    ev_t e;
    if (exp_q.size() == 0) begin
      check_eq($sformatf("unexpected_event_i%0d_k%0d", inst, kind), cyc, -1);
    end else begin
      e = exp_q.pop_front();
      check_eq("event_inst", inst, e.inst);
      check_eq("event_kind", kind, e.kind);
      check_eq($sformatf("event_cycle_i%0d_k%0d", inst, kind), cyc, e.cyc);
      if (kind == KShift) check_eq("shift_bit_count", bc, e.bc);
    end
  endtask

  task automatic mon(input int inst, input logic ld, input logic sh, input logic sc,
                     input logic dn, input logic cs, input logic [5:0] bc);
    if (sc && !prev_sclk[inst]) match(inst, KRise, 0);
    if (sh) match(inst, KShift, int'(bc));
    if (ld) match(inst, KLoad, 0);
    if (ld || sh) check_eq("load_shift_exclusive", int'(ld && sh), 0);
    if (dn) begin
      match(inst, KDone, 0);
      check_eq("cs_low_cycles", cs_low[inst], exp_cs_low[inst]);
    end
    if (ld) cs_low[inst] = 1;
    else if (!cs) cs_low[inst]++;
    prev_sclk[inst] = sc;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, ifa.sr_load, ifa.sr_shift, ifa.sclk, ifa.done, ifa.cs_n, ifa.bit_count);
      mon(1, ifb.sr_load, ifb.sr_shift, ifb.sclk, ifb.done, ifb.cs_n, ifb.bit_count);
    end else begin
      prev_sclk[0] = 1'b0;
      prev_sclk[1] = 1'b0;
    end
  end

  task automatic push_ev(input int inst, input int kind, input int c, input int bc);
    ev_t e;
    e.inst = inst;
    e.kind = kind;
    e.cyc  = c;
    e.bc   = bc;
    exp_q.push_back(e);
  endtask

  // Start accepted on edge s; nbits shifts expected; done only for a completed transfer.
  task automatic push_xfer(input int inst, input int s, input int w, input int cd,
                           input int cs, input int nbits, input bit with_done);
    push_ev(inst, KLoad, s, 0);
    for (int k = 1; k <= nbits; k++) begin
      push_ev(inst, KRise, s + cs + cd * (2 * k - 1), 0);
      push_ev(inst, KShift, s + cs + 2 * cd * k - 1, k);
    end
    if (with_done) push_ev(inst, KDone, s + 2 * cs + 2 * cd * w, 0);
  endtask

  task automatic drive_at(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    exp_cs_low[0] = 68;
    exp_cs_low[1] = 66;
    cs_low[0] = 0;
    cs_low[1] = 0;
    rst = 1'b1;
    ifa.start = 1'b0;
    ifa.abort = 1'b0;
    ifb.start = 1'b0;
    ifb.abort = 1'b0;
    drive_at(3);
    rst = 1'b0;

    // Idle after reset
    drive_at(13);
    check_eq("idle_cs_n", int'(ifa.cs_n), 1);
    check_eq("idle_sclk", int'(ifa.sclk), 0);
    check_eq("idle_busy", int'(ifa.busy), 0);
    check_eq("idle_done", int'(ifa.done), 0);
    check_eq("idle_bit_count", int'(ifa.bit_count), 0);
    check_eq("idle_sr_load", int'(ifa.sr_load), 0);
    check_eq("idle_sr_shift", int'(ifa.sr_shift), 0);
    check_eq("idle_b_cs_n", int'(ifb.cs_n), 1);
    check_eq("idle_b_busy", int'(ifb.busy), 0);

    // Single default transfer, with a simultaneous abort in IDLE (start wins)
    s = cyc + 1;
    push_xfer(0, s, 8, 4, 2, 8, 1);
    ifa.start = 1'b1;
    ifa.abort = 1'b1;
    drive_at(s);
    ifa.start = 1'b0;
    ifa.abort = 1'b0;
    check_eq("xfer_busy", int'(ifa.busy), 1);
    check_eq("xfer_cs_n", int'(ifa.cs_n), 0);
    drive_at(s + 72);
    check_eq("xfer_pending", exp_q.size(), 0);
    check_eq("xfer_end_bit_count", int'(ifa.bit_count), 8);
    check_eq("xfer_end_busy", int'(ifa.busy), 0);

    // Extra start pulses mid-transfer are ignored
    s = cyc + 1;
    push_xfer(0, s, 8, 4, 2, 8, 1);
    ifa.start = 1'b1;
    drive_at(s);
    ifa.start = 1'b0;
    drive_at(s + 4);
    ifa.start = 1'b1;
    drive_at(s + 5);
    ifa.start = 1'b0;
    drive_at(s + 39);
    ifa.start = 1'b1;
    drive_at(s + 40);
    ifa.start = 1'b0;
    check_eq("ignored_start_busy", int'(ifa.busy), 1);
    drive_at(s + 75);
    check_eq("ignored_start_pending", exp_q.size(), 0);

    // Abort right after the third shift
    s = cyc + 1;
    push_xfer(0, s, 8, 4, 2, 3, 0);
    ifa.start = 1'b1;
    drive_at(s);
    ifa.start = 1'b0;
    drive_at(s + 25);
    check_eq("abort_pre_shift", int'(ifa.sr_shift), 1);
    ifa.abort = 1'b1;
    drive_at(s + 26);
    ifa.abort = 1'b0;
    check_eq("abort_cs_n", int'(ifa.cs_n), 1);
    check_eq("abort_sclk", int'(ifa.sclk), 0);
    check_eq("abort_busy", int'(ifa.busy), 0);
    check_eq("abort_done", int'(ifa.done), 0);
    check_eq("abort_bit_count", int'(ifa.bit_count), 3);
    drive_at(s + 80);
    check_eq("abort_pending", exp_q.size(), 0);
    check_eq("abort_bit_count_held", int'(ifa.bit_count), 3);

    // Full transfer after an abort
    s = cyc + 1;
    push_xfer(0, s, 8, 4, 2, 8, 1);
    ifa.start = 1'b1;
    drive_at(s);
    ifa.start = 1'b0;
    drive_at(s + 72);
    check_eq("post_abort_pending", exp_q.size(), 0);

    // Asynchronous reset in the middle of the second high phase
    s = cyc + 1;
    push_xfer(0, s, 8, 4, 2, 8, 1);
    ifa.start = 1'b1;
    drive_at(s);
    ifa.start = 1'b0;
    drive_at(s + 15);
    check_eq("pre_reset_sclk", int'(ifa.sclk), 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_cs_n", int'(ifa.cs_n), 1);
    check_eq("async_rst_sclk", int'(ifa.sclk), 0);
    check_eq("async_rst_busy", int'(ifa.busy), 0);
    check_eq("async_rst_bit_count", int'(ifa.bit_count), 0);
    check_eq("async_rst_sr_shift", int'(ifa.sr_shift), 0);
    exp_q.delete();
    drive_at(s + 17);
    rst = 1'b0;
    drive_at(s + 30);
    check_eq("post_reset_busy", int'(ifa.busy), 0);

    // WIDTH=32, CLK_DIV=1, CS_SETUP=1, start held high: two back-to-back transfers
    s = cyc + 1;
    push_xfer(1, s, 32, 1, 1, 32, 1);
    push_xfer(1, s + 67, 32, 1, 1, 32, 1);
    ifb.start = 1'b1;
    drive_at(s + 67);
    ifb.start = 1'b0;
    check_eq("b2b_second_load", int'(ifb.sr_load), 1);
    drive_at(s + 140);
    check_eq("b2b_pending", exp_q.size(), 0);
    check_eq("b2b_bit_count", int'(ifb.bit_count), 32);
    check_eq("b2b_cs_n", int'(ifb.cs_n), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
